// File: rtl/pixel_raster_tagger.sv
// Raster position tracker: re-emits each valid pixel one cycle later, tagged with
// its column/row position, frame-edge flags, end-of-frame and a sticky sync error.
module pixel_raster_tagger #(
    parameter int DW   = 8,
    parameter int XB   = 10,
    parameter int YB   = 10,
    parameter int COLS = 640,
    parameter int ROWS = 480
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    input  logic          i_sof,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [XB-1:0] o_x,
    output logic [YB-1:0] o_y,
    output logic          o_col1,
    output logic          o_colN,
    output logic          o_row1,
    output logic          o_rowM,
    output logic          o_eof,
    output logic          o_sync_err
);

    typedef enum logic {WAIT_SOF, ACTIVE} state_t;

    localparam logic [XB-1:0] XLAST = XB'(COLS - 1);
    localparam logic [YB-1:0] YLAST = YB'(ROWS - 1);

    state_t        state_q, state_d;
    logic [XB-1:0] cx_q, cx_d;
    logic [YB-1:0] cy_q, cy_d;
    logic          accept;
    logic          badSof;
    logic [XB-1:0] px;
    logic [YB-1:0] py;

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic [XB-1:0] x_q;
    logic [YB-1:0] y_q;
    logic          col1_q, colN_q, row1_q, rowM_q, eof_q, syncErr_q;

    // A start-of-frame pixel always lands at (0,0); otherwise it takes the tracked position.
    always_comb begin
        accept  = i_valid && ((state_q == ACTIVE) || i_sof);
        badSof  = i_valid && i_sof && (state_q == ACTIVE) && ((cx_q != '0) || (cy_q != '0));
        px      = i_sof ? '0 : cx_q;
        py      = i_sof ? '0 : cy_q;
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        if (accept) begin
            state_d = ACTIVE;
            if (px == XLAST) begin
                cx_d = '0;
                cy_d = (py == YLAST) ? '0 : py + 1'b1;
            end else begin
                cx_d = px + 1'b1;
                cy_d = py;
            end
        end
    end

    // Data and coordinates hold through gaps; tag flags are forced low whenever o_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_SOF;
            cx_q      <= '0;
            cy_q      <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            col1_q    <= 1'b0;
            colN_q    <= 1'b0;
            row1_q    <= 1'b0;
            rowM_q    <= 1'b0;
            eof_q     <= 1'b0;
            syncErr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            valid_q <= accept;
            col1_q  <= accept && (px == '0);
            colN_q  <= accept && (px == XLAST);
            row1_q  <= accept && (py == '0);
            rowM_q  <= accept && (py == YLAST);
            eof_q   <= accept && (px == XLAST) && (py == YLAST);
            if (accept) begin
                data_q <= i_data;
                x_q    <= px;
                y_q    <= py;
            end
            if (badSof) begin
                syncErr_q <= 1'b1;
            end
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_x        = x_q;
    assign o_y        = y_q;
    assign o_col1     = col1_q;
    assign o_colN     = colN_q;
    assign o_row1     = row1_q;
    assign o_rowM     = rowM_q;
    assign o_eof      = eof_q;
    assign o_sync_err = syncErr_q;

endmodule

// File: tb/tb_pixel_raster_tagger.sv
// Scoreboard bench for pixel_raster_tagger on a 4x3 raster: a linear pixel-index
// model predicts every output cycle, and each scenario task checks its own results.
module tb_pixel_raster_tagger;

    localparam int DW   = 8;
    localparam int XB   = 10;
    localparam int YB   = 10;
    localparam int COLS = 4;
    localparam int ROWS = 3;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] data;
        logic [XB-1:0] x;
        logic [YB-1:0] y;
        logic          col1;
        logic          colN;
        logic          row1;
        logic          rowM;
        logic          eof;
        logic          err;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_sof = 1'b0;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic [XB-1:0] o_x;
    logic [YB-1:0] o_y;
    logic          o_col1, o_colN, o_row1, o_rowM, o_eof, o_sync_err;

    obs_t obs;
    obs_t exp;
    obs_t sbq[$];

    int numTests = 0;
    int numFails = 0;

    // Reference model state: position as a linear index into the frame.
    int            mIdx    = 0;
    bit            mActive = 0;
    bit            mErr    = 0;
    logic [DW-1:0] mData   = '0;
    logic [XB-1:0] mX      = '0;
    logic [YB-1:0] mY      = '0;

    pixel_raster_tagger #(.DW(DW), .XB(XB), .YB(YB), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_sof(i_sof),
        .o_valid(o_valid), .o_data(o_data), .o_x(o_x), .o_y(o_y),
        .o_col1(o_col1), .o_colN(o_colN), .o_row1(o_row1), .o_rowM(o_rowM),
        .o_eof(o_eof), .o_sync_err(o_sync_err)
    );

    always #5 clk = ~clk;

    assign obs = {o_valid, o_data, o_x, o_y, o_col1, o_colN, o_row1, o_rowM, o_eof, o_sync_err};

    // Drive one cycle, predict its output, step past the edge and queue the prediction.
    task automatic applyStimulus(input logic r, input logic v, input logic [DW-1:0] d, input logic s);
        obs_t e;
        int   ex, ey;
        rst     = r;
        i_valid = v;
        i_data  = d;
        i_sof   = s;
        e = '0;
        if (r) begin
            mIdx = 0; mActive = 0; mErr = 0;
            mData = '0; mX = '0; mY = '0;
        end else if (v && (mActive || s)) begin
            if (s && mActive && mIdx != 0) mErr = 1;
            if (s) mIdx = 0;
            ex = mIdx % COLS;
            ey = mIdx / COLS;
            mData = d;
            mX = XB'(ex);
            mY = YB'(ey);
            e.valid = 1'b1;
            e.col1  = (ex == 0);
            e.colN  = (ex == COLS - 1);
            e.row1  = (ey == 0);
            e.rowM  = (ey == ROWS - 1);
            e.eof   = (mIdx == COLS * ROWS - 1);
            mIdx    = (mIdx + 1) % (COLS * ROWS);
            mActive = 1;
        end
        e.data = mData;
        e.x    = mX;
        e.y    = mY;
        e.err  = mErr;
        @(posedge clk);
        #1;
        sbq.push_back(e);
    endtask

    task automatic test_reset;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1);
        while (sbq.size() > 0) begin
            exp = sbq.pop_front();
            numTests++;
            if (obs !== exp || obs !== obs_t'(0)) begin
                numFails++;
                $display("[TB] FAIL reset: got %h expected %h", obs, exp);
            end
        end
    endtask

    task automatic test_full_frame;
        for (int i = 0; i < COLS * ROWS; i++) begin
            applyStimulus(1'b0, 1'b1, DW'(i), i == 0);
            exp = sbq.pop_front();
            numTests++;
            if (obs !== exp) begin
                numFails++;
                $display("[TB] FAIL full_frame px%0d: got %h expected %h", i, obs, exp);
            end
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        exp = sbq.pop_front();
        numTests++;
        if (obs !== exp) begin
            numFails++;
            $display("[TB] FAIL full_frame idle: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_gaps;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        void'(sbq.pop_front());
        for (int i = 0; i < 2 * COLS * ROWS; i++) begin
            applyStimulus(1'b0, (i % 2) == 0, DW'(8'h10 + i / 2), i == 0);
            exp = sbq.pop_front();
            numTests++;
            if (obs !== exp) begin
                numFails++;
                $display("[TB] FAIL gaps cyc%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_drop_before_sof;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        void'(sbq.pop_front());
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, i != 6, DW'(8'h40 + i), i == 6 ? 1'b0 : (i == 7));
            exp = sbq.pop_front();
            numTests++;
            if (obs !== exp || (i < 7 && obs.valid !== 1'b0)) begin
                numFails++;
                $display("[TB] FAIL drop_before_sof cyc%0d: got %h expected %h", i, obs, exp);
            end
        end
        numTests++;
        if (!(o_col1 === 1'b1 && o_row1 === 1'b1 && o_x === '0 && o_y === '0)) begin
            numFails++;
            $display("[TB] FAIL drop_before_sof first: got x=%0d y=%0d col1=%b row1=%b expected 0 0 1 1",
                     o_x, o_y, o_col1, o_row1);
        end
    endtask

    task automatic test_back_to_back;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        void'(sbq.pop_front());
        for (int i = 0; i < COLS * ROWS + 4; i++) begin
            applyStimulus(1'b0, 1'b1, DW'(8'h80 + i), i == 0);
            exp = sbq.pop_front();
            numTests++;
            if (obs !== exp) begin
                numFails++;
                $display("[TB] FAIL back_to_back px%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_sync_err;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        void'(sbq.pop_front());
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, DW'(8'hC0 + i), i == 0 || i == 5);
            exp = sbq.pop_front();
            numTests++;
            if (obs !== exp) begin
                numFails++;
                $display("[TB] FAIL sync_err px%0d: got %h expected %h", i, obs, exp);
            end
        end
        numTests++;
        if (o_sync_err !== 1'b1) begin
            numFails++;
            $display("[TB] FAIL sync_err sticky: got %b expected 1", o_sync_err);
        end
    endtask

    task automatic test_reset_midframe;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, DW'(8'hE0 + i), i == 0);
        end
        applyStimulus(1'b1, 1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, DW'(8'hF0 + i), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, DW'(8'hF8 + i), i == 0);
        end
        for (int i = 0; sbq.size() > 0; i++) begin
            exp = sbq.pop_front();
            numTests++;
            if (i == 6 && exp !== obs_t'(0)) begin
                numFails++;
                $display("[TB] FAIL reset_midframe model: got %h expected 0", exp);
            end
        end
        numTests++;
        if (obs !== exp || o_sync_err !== 1'b0 || o_x !== XB'(2) || o_y !== '0) begin
            numFails++;
            $display("[TB] FAIL reset_midframe restart: got %h expected %h", obs, exp);
        end
    endtask

    // Reset mid-frame is observed cycle by cycle: its own dedicated stream.
    task automatic test_reset_observed;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(i == 6, 1'b1, DW'(8'h20 + i), i == 0 || i == 9);
            exp = sbq.pop_front();
            numTests++;
            if (obs !== exp) begin
                numFails++;
                $display("[TB] FAIL reset_observed cyc%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_full_frame();
        test_gaps();
        test_drop_before_sof();
        test_back_to_back();
        test_sync_err();
        test_reset_midframe();
        test_sync_err();
        test_reset_observed();
        $display("[TB] %0d tests run, %0d failed", numTests, numFails);
        $finish;
    end

endmodule

// File: doc/pixel_raster_tagger.md
Name: pixel_raster_tagger

Overview:
- Upstream stage of the horizontal edge detector in the low-pass filter path.
- Takes a raw raster pixel stream (valid-qualified, may contain gaps) and tracks column/row position.
- Re-emits each pixel one cycle later, tagged with first-column, last-column, first-row and last-row flags. The edge detector consumes these flags as i_col1, i_colN and i_rowM.
- Also reports frame completion and raster synchronisation errors.

Parameters:
- DW, 8, pixel data width in bits
- XB, 10, column counter width in bits
- YB, 10, row counter width in bits
- COLS, 640, pixels per row; range 2..2^XB
- ROWS, 480, rows per frame; range 2..2^YB

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- i_valid  input  1  input pixel valid; one pixel per cycle when high
- i_data  input  DW  input pixel value
- i_sof  input  1  start-of-frame marker; qualified by i_valid
- o_valid  output  1  output pixel valid
- o_data  output  DW  registered copy of i_data
- o_x  output  XB  column index of o_data, 0..COLS-1
- o_y  output  YB  row index of o_data, 0..ROWS-1
- o_col1  output  1  pixel is column 0
- o_colN  output  1  pixel is column COLS-1
- o_row1  output  1  pixel is in row 0
- o_rowM  output  1  pixel is in row ROWS-1
- o_eof  output  1  pixel is the last pixel of the frame
- o_sync_err  output  1  sticky: i_sof arrived when the raster was not at (0,0)

Behaviour:
- Reset (rst=1 at a clock edge): all outputs 0, including o_data, o_x, o_y and o_sync_err; column counter cx=0, row counter cy=0; state WAIT_SOF.
- Reset mid-frame: discards the frame in progress. No flags are emitted until the next i_sof.
- Latency: exactly 1 cycle. A pixel accepted at edge k appears on o_* after edge k.
- Input is never back-pressured.
- o_valid = registered i_valid, gated by state as below.
- Tag flags and o_eof are 0 whenever o_valid=0.
- o_data, o_x and o_y hold their last value when o_valid=0.
- States:
  - WAIT_SOF:
    - Pixels without i_sof are dropped; o_valid stays 0.
    - i_valid & i_sof: emit the pixel at (0,0), set cx=1 and cy=0, go to ACTIVE.
  - ACTIVE: each i_valid pixel is emitted with the current (cx, cy), then counters advance:
    - cx==COLS-1: cx=0, cy=cy+1.
    - cx==COLS-1 and cy==ROWS-1: cx=0, cy=0, and that pixel carries o_eof=1.
    - Cycles with i_valid=0 change nothing.
  - After o_eof the block stays in ACTIVE. The next pixel is (0,0) whether or not it carries i_sof.
- Tag definitions, evaluated on the emitted coordinates:
  - o_col1 = (x==0)
  - o_colN = (x==COLS-1)
  - o_row1 = (y==0)
  - o_rowM = (y==ROWS-1)
  - o_eof = o_colN & o_rowM
- i_sof in ACTIVE at a pixel whose position is (0,0): normal; no error.
- i_sof in ACTIVE at a pixel whose position is not (0,0):
  - The pixel is emitted as (0,0) and cx/cy restart (cx=1, cy=0).
  - o_sync_err is set to 1 from the output cycle of that pixel.
  - o_sync_err is cleared only by rst.
- i_sof with i_valid=0 is ignored.
- Counter compares use exact equality against COLS-1 and ROWS-1. Counters never exceed these bounds, so there is no wrap-around past 2^XB or 2^YB.

Test Plan:
- COLS=4, ROWS=3, rst then 12 back-to-back pixels 0..11, first with i_sof -> o_valid one cycle later, o_data 0..11; o_col1 on x=0; o_colN on data 3, 7, 11; o_row1 on data 0-3; o_rowM on data 8-11; o_eof only on data 11; o_sync_err=0.
- Same frame with i_valid low every other cycle -> identical tag sequence at the output, gaps where o_valid=0, flags 0 in the gaps, o_x/o_y held through the gaps.
- Pixels 0..5 without i_sof after rst -> no o_valid. Then i_sof pixel -> emitted as (0,0) with o_col1=1 and o_row1=1.
- Frame of 12 pixels immediately followed by 4 pixels without i_sof -> the 13th pixel is x=0, y=0 with o_col1=1 and o_row1=1; no error.
- i_sof at the 6th pixel (position (1,1)) -> that pixel is emitted with o_x=0, o_y=0; o_sync_err=1 and stays 1; the following pixels count from (1,0).
- rst asserted at pixel (2,1) -> all outputs 0 next cycle. Following pixels without i_sof are dropped; the next i_sof restarts at (0,0) with o_sync_err=0.
